// File: rtl/sig_debounce.sv
// sig_debounce: synchronises an asynchronous qualifier input to mclk and
// debounces it with a programmable stability count. It produces a clean
// registered level, single-cycle rise/fall pulses, a busy flag while a
// candidate transition is being checked, and a saturating glitch counter.

// Multi-flop synchroniser for one asynchronous bit.
module sig_debounce_sync #(
    parameter int STAGES = 2
) (
    input  logic mclk,
    input  logic mreset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] pipe;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge mclk or negedge mreset_n) begin
        if (!mreset_n) pipe <= '0;
        else           pipe <= {pipe[STAGES-2:0], d};
    end

    assign q = pipe[STAGES-1];
endmodule

// Saturating 8-bit event counter with a clear that beats the increment.
module sig_debounce_glitch_ctr (
    input  logic       mclk,
    input  logic       mreset_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt
);
    // Clear has priority; otherwise count up and stick at 255.
    always_ff @(posedge mclk or negedge mreset_n) begin
        if (!mreset_n)                 cnt <= 8'd0;
        else if (clr)                  cnt <= 8'd0;
        else if (inc && cnt != 8'hFF)  cnt <= cnt + 8'd1;
    end
endmodule

module sig_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 16,
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic             mclk,
    input  logic             mreset_n,
    input  logic             din,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             glitch_clr,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy,
    output logic [7:0]       glitch_cnt
);
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEF_T = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] te_q, te_d;
    logic [CNT_W-1:0] te_eff;
    logic             cnt_last;
    logic             level_d, rise_d, fall_d, busy_d;
    logic             glitch_inc;
    logic             s;

    sig_debounce_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .mclk     (mclk),
        .mreset_n (mreset_n),
        .d        (din),
        .q        (s)
    );

    // A zero threshold selects the built-in default; this value is only
    // captured on check entry so later cfg_thresh edits leave a running
    // check alone.
    assign te_eff   = (cfg_thresh == '0) ? DEF_T : cfg_thresh;
    // te_q is at least 1 whenever a check is running, so no underflow here.
    assign cnt_last = (cnt_q == te_q - ONE);

    // Next-state, counter, threshold latch and output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        te_d       = te_q;
        level_d    = level_out;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_inc = 1'b0;
        case (state_q)
            IDLE_LO: begin
                if (cfg_en && s) begin
                    state_d = CHK_HI;
                    cnt_d   = '0;
                    te_d    = te_eff;
                end
            end
            CHK_HI: begin
                if (!cfg_en) begin
                    state_d = IDLE_LO;
                end else if (!s) begin
                    state_d    = IDLE_LO;
                    glitch_inc = 1'b1;
                end else if (cnt_last) begin
                    state_d = IDLE_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            IDLE_HI: begin
                if (cfg_en && !s) begin
                    state_d = CHK_LO;
                    cnt_d   = '0;
                    te_d    = te_eff;
                end
            end
            CHK_LO: begin
                if (!cfg_en) begin
                    state_d = IDLE_HI;
                end else if (s) begin
                    state_d    = IDLE_HI;
                    glitch_inc = 1'b1;
                end else if (cnt_last) begin
                    state_d = IDLE_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE_LO;
        endcase
        busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
    end

    // State, counter, latched threshold and registered outputs.
    always_ff @(posedge mclk or negedge mreset_n) begin
        if (!mreset_n) begin
            state_q    <= IDLE_LO;
            cnt_q      <= '0;
            te_q       <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            te_q       <= te_d;
            level_out  <= level_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
            busy       <= busy_d;
        end
    end

    sig_debounce_glitch_ctr u_glitch (
        .mclk     (mclk),
        .mreset_n (mreset_n),
        .clr      (glitch_clr),
        .inc      (glitch_inc),
        .cnt      (glitch_cnt)
    );
endmodule

// File: tb/tb_sig_debounce.sv
// tb_sig_debounce: directed scenarios plus randomized stimulus, all compared
// cycle by cycle against a behavioural model of the debouncer.
module tb_sig_debounce;
    localparam int SYNC = 2;
    localparam int CW   = 16;
    localparam int DEF  = 1000;

    logic          mclk = 1'b0;
    logic          mreset_n = 1'b0;
    logic          din = 1'b0;
    logic          cfg_en = 1'b0;
    logic [CW-1:0] cfg_thresh = '0;
    logic          glitch_clr = 1'b0;
    logic          level_out, rise_pulse, fall_pulse, busy;
    logic [7:0]    glitch_cnt;

    int errs   = 0;
    int checks = 0;

    // Behavioural model: a delay line for the synchroniser, and a
    // "pending candidate" described by its age and captured threshold.
    bit q[$];
    bit m_pend, m_lvl, m_rise, m_fall;
    int m_age, m_te, m_g;

    sig_debounce #(.SYNC_STAGES(SYNC), .CNT_W(CW), .DEBOUNCE_CYC(DEF)) dut (
        .mclk       (mclk),
        .mreset_n   (mreset_n),
        .din        (din),
        .cfg_en     (cfg_en),
        .cfg_thresh (cfg_thresh),
        .glitch_clr (glitch_clr),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < SYNC; i++) q.push_back(1'b0);
        m_pend = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
        m_age = 0; m_te = 0; m_g = 0;
    endtask

    // One clock edge: the candidate must differ from the accepted level for
    // Te consecutive synchronised samples with the enable held.
    task automatic model_edge();
        bit s;
        bit inc;
        s = q.pop_front();
        q.push_back(din);
        m_rise = 0; m_fall = 0; inc = 0;
        if (!m_pend) begin
            if (cfg_en && s != m_lvl) begin
                m_pend = 1;
                m_age  = 0;
                m_te   = (cfg_thresh == 0) ? DEF : int'(cfg_thresh);
            end
        end else if (!cfg_en) begin
            m_pend = 0;
        end else if (s == m_lvl) begin
            m_pend = 0;
            inc    = 1;
        end else if (m_age + 1 == m_te) begin
            m_pend = 0;
            m_lvl  = !m_lvl;
            if (m_lvl) m_rise = 1; else m_fall = 1;
        end else begin
            m_age++;
        end
        if (glitch_clr) m_g = 0;
        else if (inc)   m_g = (m_g < 255) ? m_g + 1 : 255;
    endtask

    task automatic compare_all();
        chk("level_out",  level_out,  m_lvl);
        chk("rise_pulse", rise_pulse, m_rise);
        chk("fall_pulse", fall_pulse, m_fall);
        chk("busy",       busy,       m_pend);
        chk("glitch_cnt", glitch_cnt, m_g);
    endtask

    // Drive at the falling edge, advance the model at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input bit d, input bit en, input int thr, input bit clr);
        din        = d;
        cfg_en     = en;
        cfg_thresh = thr[CW-1:0];
        glitch_clr = clr;
        @(posedge mclk);
        if (mreset_n) model_edge();
        @(negedge mclk);
        compare_all();
    endtask

    task automatic settle(input bit d, input int n);
        for (int i = 0; i < n; i++) cycle(d, 1'b1, 4, 1'b0);
    endtask

    // Hold din at d; index 0 is the edge that first samples d. Reports the
    // edge index of the wanted pulse (-1 if never seen) and busy cycles.
    task automatic hold_until(input bit d, input int thr_a, input int thr_b, input int sw,
                              input bit want_rise, input int limit,
                              output int edges, output int busy_n);
        edges  = -1;
        busy_n = 0;
        for (int i = 0; i < limit; i++) begin
            cycle(d, 1'b1, (i < sw) ? thr_a : thr_b, 1'b0);
            if ((want_rise ? rise_pulse : fall_pulse) === 1'b1) begin
                edges = i;
                break;
            end
            if (busy === 1'b1) busy_n++;
        end
    endtask

    initial begin
        int e, b, rd, rlen, rthr;
        bit ren, rclr;
        model_reset();
        @(negedge mclk);
        @(negedge mclk);
        compare_all();
        mreset_n = 1'b1;

        // Basic rise with Te=4.
        settle(0, 4);
        hold_until(1, 4, 4, 0, 1'b1, 40, e, b);
        chk("rise_latency", e, 6);
        chk("rise_busy_cycles", b, 4);
        cycle(1, 1'b1, 4, 1'b0);
        chk("rise_one_cycle", rise_pulse, 0);

        // Fall with the default threshold.
        hold_until(0, 0, 0, 0, 1'b0, 1100, e, b);
        chk("fall_latency_default", e, 1002);
        chk("fall_level", level_out, 0);

        // Threshold edited during the check, then used for the next one.
        hold_until(1, 4, 10, 3, 1'b1, 40, e, b);
        chk("thresh_change_rise", e, 6);
        hold_until(0, 10, 10, 0, 1'b0, 40, e, b);
        chk("thresh_next_fall", e, 12);

        // Glitches: first one counts 1, 300 of them saturate.
        settle(0, 4);
        for (int g = 0; g < 300; g++) begin
            cycle(1, 1'b1, 4, 1'b0);
            cycle(1, 1'b1, 4, 1'b0);
            for (int i = 0; i < 4; i++) cycle(0, 1'b1, 4, 1'b0);
            if (g == 0) begin
                chk("glitch_first", glitch_cnt, 1);
                chk("glitch_level", level_out, 0);
            end
        end
        chk("glitch_sat", glitch_cnt, 255);

        // Clear arriving on the same edge as an abort wins.
        cycle(1, 1'b1, 4, 1'b0);
        cycle(1, 1'b1, 4, 1'b0);
        for (int i = 0; i < 4; i++) cycle(0, 1'b1, 4, m_pend && q[0] == m_lvl);
        chk("glitch_clr_prio", glitch_cnt, 0);

        // Enable dropped mid-check: back to idle, nothing counted.
        for (int i = 0; i < 4; i++) cycle(1, 1'b1, 4, 1'b0);
        cycle(1, 1'b0, 4, 1'b0);
        chk("en_drop_busy", busy, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1'b0, 4, 1'b0);
        chk("en_drop_glitch", glitch_cnt, 0);
        chk("en_drop_level", level_out, 0);

        // Reset in the middle of a falling check, din high at release.
        hold_until(1, 4, 4, 0, 1'b1, 40, e, b);
        settle(1, 2);
        for (int i = 0; i < 4; i++) cycle(0, 1'b1, 4, 1'b0);
        chk("pre_reset_busy", busy, 1);
        mreset_n = 1'b0;
        din      = 1'b1;
        #1;
        chk("rst_level", level_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_glitch", glitch_cnt, 0);
        model_reset();
        @(negedge mclk);
        cycle(1, 1'b1, 4, 1'b0);
        cycle(1, 1'b1, 4, 1'b0);
        mreset_n = 1'b1;
        hold_until(1, 4, 4, 0, 1'b1, 40, e, b);
        chk("post_reset_rise", e, 6);

        // Randomized runs of mixed length, enables, thresholds and clears.
        rthr = 3;
        for (int r = 0; r < 250; r++) begin
            rd   = int'($urandom_range(0, 1));
            rlen = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 16));
            for (int j = 0; j < rlen; j++) begin
                if ($urandom_range(0, 7) == 0) rthr = int'($urandom_range(1, 6));
                ren  = ($urandom_range(0, 24) != 0);
                rclr = ($urandom_range(0, 39) == 0) ||
                       (($urandom_range(0, 3) == 0) && m_pend && ren && q[0] == m_lvl);
                cycle(rd[0], ren, rthr, rclr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/sig_debounce.md
Name: sig_debounce

Overview:
- Upstream conditioning stage for the control state machines that take single-bit qualifier inputs; its level_out drives the machine's "a"-type input.
- Synchronises an asynchronous input to mclk and debounces it with a programmable stability count.
- Emits a clean level plus single-cycle rise/fall pulses.
- Counts rejected glitches for diagnostics.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on din (legal 2..4).
- CNT_W, 16, width of stability counter and cfg_thresh.
- DEBOUNCE_CYC, 1000, default threshold used when cfg_thresh==0 (1..2^CNT_W-1).

Ports:
- mclk  in  1  system clock.
- mreset_n  in  1  reset, asynchronous, active-low.
- din  in  1  raw asynchronous input.
- cfg_en  in  1  debounce enable; 0 aborts checks and freezes level_out.
- cfg_thresh  in  CNT_W  stability threshold T in cycles; 0 selects DEBOUNCE_CYC.
- glitch_clr  in  1  synchronous clear of glitch_cnt.
- level_out  out  1  debounced level (registered).
- rise_pulse  out  1  one-cycle pulse on accepted 0->1.
- fall_pulse  out  1  one-cycle pulse on accepted 1->0.
- busy  out  1  high while in CHK_HI or CHK_LO.
- glitch_cnt  out  8  saturating count of aborted checks.

Behaviour:
- Reset (async, mreset_n low):
  - Synchroniser flops = 0, state = IDLE_LO, counter = 0, latched threshold = 0.
  - level_out = 0, rise_pulse = 0, fall_pulse = 0, busy = 0, glitch_cnt = 0.
  - Reset mid-check discards the check; no pulse, no glitch count.
- Synchroniser: din passes through SYNC_STAGES flops; s = last flop output. All FSM decisions use s only.
- Effective threshold: Te = (cfg_thresh==0) ? DEBOUNCE_CYC : cfg_thresh. Te is latched on entry to CHK_HI/CHK_LO; changing cfg_thresh mid-check has no effect on that check.
- FSM states and transitions:
  - IDLE_LO:
    - cfg_en & s=1 -> CHK_HI; counter = 0; latch Te.
  - CHK_HI:
    - cfg_en=0 -> IDLE_LO; no glitch count.
    - s=0 -> IDLE_LO; glitch_cnt += 1.
    - s=1 & counter==Te-1 -> IDLE_HI; level_out <= 1; rise_pulse <= 1 for one cycle.
    - otherwise s=1 -> counter += 1.
  - IDLE_HI:
    - cfg_en & s=0 -> CHK_LO; counter = 0; latch Te.
  - CHK_LO: mirror of CHK_HI.
    - s=1 aborts to IDLE_HI with glitch_cnt += 1.
    - Acceptance -> IDLE_LO; level_out <= 0; fall_pulse <= 1.
- Latency: din stable from sampling edge k -> level_out changes and pulse asserts at edge k+SYNC_STAGES+Te; pulse deasserts next edge.
- level_out changes only on acceptance; it never toggles on glitches or when cfg_en=0.
- busy = (state is CHK_HI or CHK_LO), registered with state.
- rise_pulse and fall_pulse are never high simultaneously, and never high in consecutive cycles.
- glitch_cnt:
  - Saturates at 255.
  - glitch_clr has priority: clr and increment in the same cycle -> 0.
- Counter never exceeds Te-1; no wrap-around is possible.
- din already high at reset release -> normal CHK_HI sequence -> rise_pulse occurs after SYNC_STAGES+Te edges.
- Minimal Te=1: acceptance on the first CHK cycle. Total latency is SYNC_STAGES+1 edges.

Test Plan:
- Reset, cfg_en=1, cfg_thresh=4, din 0->1 held -> level_out=1 and rise_pulse=1 exactly 6 edges after the first high sample; rise_pulse low on the next edge; busy high for 4 cycles before that.
- cfg_thresh=4, din high for 2 cycles then low -> level_out stays 0, no pulse, glitch_cnt=1; repeating 300 times -> glitch_cnt=255.
- From level_out=1, din 1->0 held with cfg_thresh=0 (Te=1000) -> fall_pulse at edge 1002; level_out=0.
- cfg_thresh changed 4->10 on the second CHK_HI cycle -> acceptance still at 6 edges total; the next transition uses 10.
- cfg_en dropped mid CHK_HI -> state returns to IDLE_LO, glitch_cnt unchanged, level_out held 0; glitch_clr asserted with a simultaneous glitch -> glitch_cnt=0.
- mreset_n asserted mid CHK_LO, with din held high at release -> all outputs 0 immediately; then rise_pulse after 2+Te edges.
